lock_chamber_ctrl: RTL and testbench

- Controls the water level of a canal lock chamber between a low pool level and a high pool level.
- Fills or drains the chamber one step per rate tick, on request.
- Drives the chamber level and status flags consumed downstream by the gondola gate logic, which compares chamber level against each pool.
- Progress is interlocked: the level moves only while both gates report closed.

---
 rtl/lock_chamber_ctrl_pkg.sv | 10 +
 rtl/lock_chamber_ctrl_if.sv | 23 ++
 rtl/lock_tick_div.sv | 19 +
 rtl/lock_chamber_ctrl.sv | 77 +++++++
 tb/tb_lock_chamber_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/lock_chamber_ctrl_pkg.sv
// lock_pkg: shared lock-chamber state encoding, default levels and gate tolerance.
package lock_pkg;
  typedef enum logic [1:0] {LOW, FILL, HIGH, DRAIN} lock_state_t;
  localparam int LEVEL_W_DEF    = 8;
  localparam int LOW_LEVEL_DEF  = 40;
  localparam int HIGH_LEVEL_DEF = 80;
  localparam int STEP_DEF       = 5;
  localparam int TICK_DEF       = 50_000_000;
  localparam int GATE_TOL       = 3;
endpackage

// File: rtl/lock_chamber_ctrl_if.sv
// lock_chamber_ctrl_if: request/interlock inputs and level/status outputs of the chamber controller.
interface lock_chamber_ctrl_if
  import lock_pkg::*;
#(
  parameter int LEVEL_W = LEVEL_W_DEF
);
  logic               raise_req;
  logic               lower_req;
  logic               gates_closed;
  logic [LEVEL_W-1:0] level;
  logic               at_low;
  logic               at_high;
  logic               filling;
  logic               draining;
  modport master (
    output raise_req, lower_req, gates_closed,
    input  level, at_low, at_high, filling, draining
  );
  modport slave (
    input  raise_req, lower_req, gates_closed,
    output level, at_low, at_high, filling, draining
  );
endinterface

// File: rtl/lock_tick_div.sv
// lock_tick_div: counts enabled cycles and emits a one-cycle tick every TICK_CYCLES of them.
module lock_tick_div #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = enable && (cnt_q == LAST);
    cnt_d = clear ? '0 : !enable ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/lock_chamber_ctrl.sv
// lock_chamber_ctrl: steps chamber level between low and high pool while both gates are closed.
// Define LOCK_REVERSE_EN to let an opposite request reverse a fill or drain in progress.
module lock_chamber_ctrl
  import lock_pkg::*;
#(
  parameter int LEVEL_W     = LEVEL_W_DEF,
  parameter int LOW_LEVEL   = LOW_LEVEL_DEF,
  parameter int HIGH_LEVEL  = HIGH_LEVEL_DEF,
  parameter int STEP        = STEP_DEF,
  parameter int TICK_CYCLES = TICK_DEF
) (
  input logic                 clk,
  input logic                 reset,
  lock_chamber_ctrl_if.slave  bus
);
`ifdef LOCK_REVERSE_EN
  localparam bit REVERSE = 1'b1;
`else
  localparam bit REVERSE = 1'b0;
`endif
  localparam logic [LEVEL_W-1:0] LO   = LEVEL_W'(LOW_LEVEL);
  localparam logic [LEVEL_W-1:0] HI   = LEVEL_W'(HIGH_LEVEL);
  localparam logic [LEVEL_W:0]   HI_W = (LEVEL_W + 1)'(HIGH_LEVEL);
  localparam logic [LEVEL_W:0]   FLOOR_W = (LEVEL_W + 1)'(LOW_LEVEL + STEP);
  localparam logic [LEVEL_W:0]   STEP_W  = (LEVEL_W + 1)'(STEP);
  lock_state_t        state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W:0]   sum_w;
  logic               clear, enable, tick;
  lock_tick_div #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (clear),
    .tick   (tick)
  );
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    clear   = 1'b0;
    enable  = ((state_q == FILL) || (state_q == DRAIN)) && bus.gates_closed;
    sum_w   = {1'b0, level_q} + STEP_W;
    case (state_q)
      LOW: if (bus.raise_req) begin
        state_d = FILL;
        clear   = 1'b1;
      end
      HIGH: if (bus.lower_req) begin
        state_d = DRAIN;
        clear   = 1'b1;
      end
      FILL: if (REVERSE && bus.lower_req && !bus.raise_req) begin
        state_d = DRAIN;
        clear   = 1'b1;
      end else if (tick) begin
        state_d = (sum_w >= HI_W) ? HIGH : FILL;
        level_d = (sum_w >= HI_W) ? HI : sum_w[LEVEL_W-1:0];
      end
      default: if (REVERSE && bus.raise_req && !bus.lower_req) begin
        state_d = FILL;
        clear   = 1'b1;
      end else if (tick) begin
        state_d = ({1'b0, level_q} <= FLOOR_W) ? LOW : DRAIN;
        level_d = ({1'b0, level_q} <= FLOOR_W) ? LO : level_q - STEP_W[LEVEL_W-1:0];
      end
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? LOW : state_d;
    level_q <= reset ? LO : level_d;
  end
  assign bus.level    = level_q;
  assign bus.at_low   = state_q == LOW;
  assign bus.at_high  = state_q == HIGH;
  assign bus.filling  = state_q == FILL;
  assign bus.draining = state_q == DRAIN;
endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// tb_lock_chamber_ctrl: directed checks of fill, drain, interlock, saturation and request handling.
module tb_lock_chamber_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  lock_chamber_ctrl_if #(.LEVEL_W(8)) ia ();
  lock_chamber_ctrl_if #(.LEVEL_W(8)) ib ();
  lock_chamber_ctrl #(.TICK_CYCLES(4), .STEP(5)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  lock_chamber_ctrl #(.TICK_CYCLES(4), .STEP(7)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    checks++;
    if (ia.level !== 8'd40) begin errors++; $display("FAIL reset_level: got %0d expected 40", ia.level); end
    checks++;
    if ({ia.at_low, ia.at_high, ia.filling, ia.draining} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags: got %b expected 1000", {ia.at_low, ia.at_high, ia.filling, ia.draining});
    end
    checks++;
    if ({ib.level, ib.at_low} !== {8'd40, 1'b1}) begin errors++; $display("FAIL reset_b: got %0d/%b expected 40/1", ib.level, ib.at_low); end
  endtask

  task automatic test_full_fill();
    ia.raise_req = 1'b1;
    cyc(1);
    ia.raise_req = 1'b0;
    checks++;
    if ({ia.filling, ia.level} !== {1'b1, 8'd40}) begin errors++; $display("FAIL fill_entry: got %b/%0d expected 1/40", ia.filling, ia.level); end
    for (int i = 1; i <= 8; i++) begin
      cyc(3);
      checks++;
      if (ia.level !== 8'(40 + 5 * (i - 1))) begin errors++; $display("FAIL fill_hold%0d: got %0d expected %0d", i, ia.level, 40 + 5 * (i - 1)); end
      cyc(1);
      checks++;
      if (ia.level !== 8'(40 + 5 * i)) begin errors++; $display("FAIL fill_step%0d: got %0d expected %0d", i, ia.level, 40 + 5 * i); end
    end
    checks++;
    if ({ia.at_high, ia.filling} !== 2'b10) begin errors++; $display("FAIL fill_high: got %b expected 10", {ia.at_high, ia.filling}); end
    cyc(3);
    checks++;
    if ({ia.at_high, ia.level} !== {1'b1, 8'd80}) begin errors++; $display("FAIL high_hold: got %b/%0d expected 1/80", ia.at_high, ia.level); end
    ia.lower_req = 1'b1;
    cyc(1);
    ia.lower_req = 1'b0;
    checks++;
    if (ia.draining !== 1'b1) begin errors++; $display("FAIL drain_entry: got %b expected 1", ia.draining); end
    cyc(32);
    checks++;
    if ({ia.at_low, ia.level} !== {1'b1, 8'd40}) begin errors++; $display("FAIL drain_low: got %b/%0d expected 1/40", ia.at_low, ia.level); end
  endtask

  task automatic test_interlock();
    ia.raise_req = 1'b1;
    cyc(1);
    ia.raise_req = 1'b0;
    cyc(14);
    ia.gates_closed = 1'b0;
    cyc(10);
    checks++;
    if ({ia.filling, ia.level} !== {1'b1, 8'd55}) begin errors++; $display("FAIL interlock_hold: got %b/%0d expected 1/55", ia.filling, ia.level); end
    ia.gates_closed = 1'b1;
    cyc(1);
    checks++;
    if (ia.level !== 8'd55) begin errors++; $display("FAIL interlock_resume1: got %0d expected 55", ia.level); end
    cyc(1);
    checks++;
    if (ia.level !== 8'd60) begin errors++; $display("FAIL interlock_resume2: got %0d expected 60", ia.level); end
    cyc(16);
    checks++;
    if ({ia.at_high, ia.level} !== {1'b1, 8'd80}) begin errors++; $display("FAIL interlock_done: got %b/%0d expected 1/80", ia.at_high, ia.level); end
    ia.lower_req = 1'b1;
    cyc(1);
    ia.lower_req = 1'b0;
    cyc(32);
    checks++;
    if (ia.at_low !== 1'b1) begin errors++; $display("FAIL interlock_back_low: got %b expected 1", ia.at_low); end
  endtask

  task automatic test_saturation();
    logic [7:0] up [6] = '{8'd47, 8'd54, 8'd61, 8'd68, 8'd75, 8'd80};
    logic [7:0] dn [6] = '{8'd73, 8'd66, 8'd59, 8'd52, 8'd45, 8'd40};
    ib.raise_req = 1'b1;
    cyc(1);
    ib.raise_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(4);
      checks++;
      if (ib.level !== up[i]) begin errors++; $display("FAIL sat_fill%0d: got %0d expected %0d", i, ib.level, up[i]); end
    end
    checks++;
    if ({ib.at_high, ib.filling} !== 2'b10) begin errors++; $display("FAIL sat_high: got %b expected 10", {ib.at_high, ib.filling}); end
    ib.lower_req = 1'b1;
    cyc(1);
    ib.lower_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(4);
      checks++;
      if (ib.level !== dn[i]) begin errors++; $display("FAIL sat_drain%0d: got %0d expected %0d", i, ib.level, dn[i]); end
    end
    checks++;
    if ({ib.at_low, ib.draining} !== 2'b10) begin errors++; $display("FAIL sat_low: got %b expected 10", {ib.at_low, ib.draining}); end
  endtask

  task automatic test_requests();
    ia.lower_req = 1'b1;
    cyc(3);
    checks++;
    if ({ia.at_low, ia.draining, ia.level} !== {2'b10, 8'd40}) begin
      errors++; $display("FAIL low_ignore: got %b%b/%0d expected 10/40", ia.at_low, ia.draining, ia.level);
    end
    ia.raise_req = 1'b1;
    cyc(1);
    ia.raise_req = 1'b0;
    ia.lower_req = 1'b0;
    checks++;
    if ({ia.filling, ia.draining} !== 2'b10) begin errors++; $display("FAIL both_low: got %b expected 10", {ia.filling, ia.draining}); end
    cyc(16);
    checks++;
    if (ia.level !== 8'd60) begin errors++; $display("FAIL pre_reset_level: got %0d expected 60", ia.level); end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    checks++;
    if ({ia.at_low, ia.filling, ia.level} !== {2'b10, 8'd40}) begin
      errors++; $display("FAIL mid_reset: got %b%b/%0d expected 10/40", ia.at_low, ia.filling, ia.level);
    end
  endtask

  task automatic test_reverse();
    ia.raise_req = 1'b1;
    cyc(1);
    ia.raise_req = 1'b0;
    cyc(16);
    checks++;
    if (ia.level !== 8'd60) begin errors++; $display("FAIL rev_pre: got %0d expected 60", ia.level); end
    ia.lower_req = 1'b1;
    cyc(1);
    ia.lower_req = 1'b0;
`ifdef LOCK_REVERSE_EN
    checks++;
    if ({ia.draining, ia.level} !== {1'b1, 8'd60}) begin errors++; $display("FAIL rev_entry: got %b/%0d expected 1/60", ia.draining, ia.level); end
    cyc(4);
    checks++;
    if (ia.level !== 8'd55) begin errors++; $display("FAIL rev_step: got %0d expected 55", ia.level); end
`else
    checks++;
    if ({ia.filling, ia.level} !== {1'b1, 8'd60}) begin errors++; $display("FAIL norev_entry: got %b/%0d expected 1/60", ia.filling, ia.level); end
    cyc(15);
    checks++;
    if ({ia.at_high, ia.level} !== {1'b1, 8'd80}) begin errors++; $display("FAIL norev_done: got %b/%0d expected 1/80", ia.at_high, ia.level); end
`endif
  endtask

  initial begin
    ia.raise_req = 1'b0; ia.lower_req = 1'b0; ia.gates_closed = 1'b1;
    ib.raise_req = 1'b0; ib.lower_req = 1'b0; ib.gates_closed = 1'b1;
    test_reset();
    test_full_fill();
    test_interlock();
    test_saturation();
    test_requests();
    test_reverse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
